// File: rtl/minesweeper_pkg.sv
// Shared board definitions for the minesweeper blocks: cell word layout,
// board address width, mine placer state encodings and a safe-zone helper.
package minesweeper_pkg;

    localparam int CELL_W        = 8;
    localparam int CELL_MINE_BIT = 7;
    localparam int BOARD_AW      = 8;

    localparam logic [CELL_W-1:0] CELL_CLEAR_WORD = 8'h00;
    localparam logic [CELL_W-1:0] CELL_MINE_WORD  = 8'h80;

    // Mine placer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLEAR   = 3'd1;
    localparam logic [2:0] ST_GEN     = 3'd2;
    localparam logic [2:0] ST_RD      = 3'd3;
    localparam logic [2:0] ST_RD_WAIT = 3'd4;
    localparam logic [2:0] ST_TEST    = 3'd5;
    localparam logic [2:0] ST_WR      = 3'd6;
    localparam logic [2:0] ST_DONE    = 3'd7;

    // True when a signed row or column difference lies in -1..+1
    function automatic logic within_one(input logic signed [8:0] d);
        return (d >= -9'sd1) && (d <= 9'sd1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11 (tap mask 16'hB400).
// next_o is the value the register takes on a step, so a consumer can use
// the freshly stepped value in the same cycle it requests the step.
module lfsr16 #(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] next_o
);

    localparam logic [15:0] TAPS = 16'hB400;

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] stepped_s;

    // Next-state selection: load wins over step, otherwise hold
    always_comb begin
        stepped_s = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
        if (load) begin
            lfsr_d = seed;
        end else if (step) begin
            lfsr_d = stepped_s;
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q <= RESET_VAL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign next_o = stepped_s;

endmodule

// File: rtl/mine_placer.sv
// Mine placer: after the first pick, clears the board RAM, then writes
// NUM_MINES distinct mines drawn from an LFSR, never inside the 3x3 zone
// around the start cell, and reports completion on mine_done.
// Optional build macro MINE_FREE_RUN_EN: the LFSR steps every clock instead
// of reloading its seed in IDLE, so the layout depends on selection time.
module mine_placer
#(
    parameter int          ROWS      = 16,
    parameter int          COLS      = 16,
    parameter int          NUM_MINES = 40,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mine_start,
    input  logic [7:0] start_cell_addr,
    output logic [7:0] mem_addr,
    output logic       mem_wr_en,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic       mine_done,
    output logic [7:0] mines_placed
);

    import minesweeper_pkg::*;

    localparam int                  COL_W      = $clog2(COLS);
    localparam logic [BOARD_AW-1:0] COL_MASK   = 8'(COLS - 1);
    localparam logic [BOARD_AW:0]   BOARD_CELLS = 9'(ROWS * COLS);
    localparam logic [BOARD_AW-1:0] LAST_CELL  = 8'(ROWS * COLS - 1);
    localparam logic [7:0]          MINE_TARGET = 8'(NUM_MINES);

    logic [2:0]          state_q, state_d;
    logic [BOARD_AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [BOARD_AW-1:0] mem_addr_q, mem_addr_d;
    logic                mem_wr_en_q, mem_wr_en_d;
    logic [CELL_W-1:0]   mem_wr_data_q, mem_wr_data_d;
    logic                mine_done_q, mine_done_d;
    logic [7:0]          mines_placed_q, mines_placed_d;

    logic [15:0]         lfsr_next_s;
    logic                lfsr_step_s;
    logic                lfsr_load_s;
    logic [BOARD_AW-1:0] cand_s;
    logic [BOARD_AW-1:0] cand_row_s, cand_col_s, start_row_s, start_col_s;
    logic signed [8:0]   d_row_s, d_col_s;
    logic                cand_ok_s;
    logic                unused_bits_s;

`ifdef MINE_FREE_RUN_EN
    assign lfsr_step_s = 1'b1;
    assign lfsr_load_s = 1'b0;
`else
    assign lfsr_step_s = (state_q == ST_GEN);
    assign lfsr_load_s = (state_q == ST_IDLE);
`endif

    lfsr16 #(
        .RESET_VAL (LFSR_SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .step   (lfsr_step_s),
        .load   (lfsr_load_s),
        .seed   (LFSR_SEED),
        .next_o (lfsr_next_s)
    );

    assign cand_s        = lfsr_next_s[BOARD_AW-1:0];
    assign unused_bits_s = ^{lfsr_next_s[15:BOARD_AW], mem_rd_data[CELL_MINE_BIT-1:0]};

    // Candidate filter: on the board and outside the clipped 3x3 safe zone
    always_comb begin
        cand_row_s  = cand_s >> COL_W;
        cand_col_s  = cand_s & COL_MASK;
        start_row_s = start_cell_addr >> COL_W;
        start_col_s = start_cell_addr & COL_MASK;
        d_row_s     = $signed({1'b0, cand_row_s}) - $signed({1'b0, start_row_s});
        d_col_s     = $signed({1'b0, cand_col_s}) - $signed({1'b0, start_col_s});
        if ({1'b0, cand_s} >= BOARD_CELLS) begin
            cand_ok_s = 1'b0;
        end else if (within_one(d_row_s) && within_one(d_col_s)) begin
            cand_ok_s = 1'b0;
        end else begin
            cand_ok_s = 1'b1;
        end
    end

    // Sequencer: next state and next values of all registered outputs
    always_comb begin
        state_d        = state_q;
        clr_cnt_d      = clr_cnt_q;
        mem_addr_d     = mem_addr_q;
        mem_wr_en_d    = 1'b0;
        mem_wr_data_d  = CELL_CLEAR_WORD;
        mine_done_d    = 1'b0;
        mines_placed_d = mines_placed_q;
        if ((state_q != ST_IDLE) && !mine_start) begin
            // Request withdrawn: stop at once, no further writes
            state_d    = ST_IDLE;
            mem_addr_d = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_addr_d = 8'd0;
                    if (mine_start) begin
                        state_d        = ST_CLEAR;
                        clr_cnt_d      = 8'd0;
                        mines_placed_d = 8'd0;
                        mem_wr_en_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    // clr_cnt_q is the address being written this cycle
                    if (clr_cnt_q == LAST_CELL) begin
                        if (NUM_MINES == 0) begin
                            state_d     = ST_DONE;
                            mine_done_d = 1'b1;
                        end else begin
                            state_d = ST_GEN;
                        end
                    end else begin
                        clr_cnt_d   = clr_cnt_q + 8'd1;
                        mem_addr_d  = clr_cnt_q + 8'd1;
                        mem_wr_en_d = 1'b1;
                    end
                end
                ST_GEN: begin
                    if (cand_ok_s) begin
                        state_d    = ST_RD;
                        mem_addr_d = cand_s;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
                ST_RD: begin
                    state_d = ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_d = ST_TEST;
                end
                ST_TEST: begin
                    if (mem_rd_data[CELL_MINE_BIT]) begin
                        state_d = ST_GEN;
                    end else begin
                        state_d        = ST_WR;
                        mem_wr_en_d    = 1'b1;
                        mem_wr_data_d  = CELL_MINE_WORD;
                        mines_placed_d = mines_placed_q + 8'd1;
                    end
                end
                ST_WR: begin
                    if (mines_placed_q == MINE_TARGET) begin
                        state_d     = ST_DONE;
                        mine_done_d = 1'b1;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
                ST_DONE: begin
                    mine_done_d = 1'b1;
                end
                default: begin
                    state_d    = ST_IDLE;
                    mem_addr_d = 8'd0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            clr_cnt_q      <= 8'd0;
            mem_addr_q     <= 8'd0;
            mem_wr_en_q    <= 1'b0;
            mem_wr_data_q  <= 8'h00;
            mine_done_q    <= 1'b0;
            mines_placed_q <= 8'd0;
        end else begin
            state_q        <= state_d;
            clr_cnt_q      <= clr_cnt_d;
            mem_addr_q     <= mem_addr_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_wr_data_q  <= mem_wr_data_d;
            mine_done_q    <= mine_done_d;
            mines_placed_q <= mines_placed_d;
        end
    end

    assign mem_addr     = mem_addr_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign mine_done    = mine_done_q;
    assign mines_placed = mines_placed_q;

endmodule
